// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    // ALU opcodes; any other selector value behaves as add.
    localparam logic [SEL_W-1:0] OP_ADD = 4'd0;
    localparam logic [SEL_W-1:0] OP_SUB = 4'd1;
    localparam logic [SEL_W-1:0] OP_MUL = 4'd2;
    localparam logic [SEL_W-1:0] OP_DIV = 4'd3;

    // Arbiter control states: one operation in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Operation captured at grant time.
    typedef struct packed {
        logic              id;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 32-bit combinational ALU: add, sub, mul (low word), unsigned div.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [DATA_W-1:0] y_c_o
);

    // Opcode decode; a zero divisor yields 0 here and is overridden upstream.
    always_comb begin
        y_c_o = a_i + b_i;
        case (sel_i)
            OP_SUB:  y_c_o = a_i - b_i;
            OP_MUL:  y_c_o = a_i * b_i;
            OP_DIV:  y_c_o = (b_i == '0) ? '0 : (a_i / b_i);
            default: y_c_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// registered response held until the consumer takes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter logic [DATA_W-1:0] DIV0_RESULT = 32'hFFFF_FFFF,
    parameter logic              RR_INIT     = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_out,
    output logic              resp_zero,
    output logic              resp_dz
);

    state_e            state_q, state_d;
    logic              prio_q;
    op_t               op_q, op_d;
    logic              grant_c, grant_id_c;
    logic [DATA_W-1:0] alu_y_c, result_c;
    logic              div0_c;

    logic              resp_valid_q;
    logic              resp_id_q;
    logic [DATA_W-1:0] resp_out_q;
    logic              resp_zero_q;
    logic              resp_dz_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant decision and operand selection; ready is the grant itself.
    always_comb begin
        state_d    = state_q;
        grant_c    = 1'b0;
        grant_id_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!reset && (req0_valid || req1_valid)) begin
                    grant_c    = 1'b1;
                    grant_id_c = (req0_valid && req1_valid) ? prio_q : req1_valid;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        op_d.id  = grant_id_c;
        op_d.sel = grant_id_c ? req1_sel : req0_sel;
        op_d.a   = grant_id_c ? req1_a   : req0_a;
        op_d.b   = grant_id_c ? req1_b   : req0_b;

        req0_ready = grant_c && !grant_id_c;
        req1_ready = grant_c &&  grant_id_c;
    end

    alu_arbiter_alu u_alu (
        .a_i   (op_q.a),
        .b_i   (op_q.b),
        .sel_i (op_q.sel),
        .y_c_o (alu_y_c)
    );

    // Divide by zero substitutes the fixed result for the ALU output.
    always_comb begin
        div0_c   = (op_q.sel == OP_DIV) && (op_q.b == '0);
        result_c = div0_c ? DIV0_RESULT : alu_y_c;
    end

    // Operand capture at grant, priority rotation, and the response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q       <= RR_INIT;
            op_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_out_q   <= '0;
            resp_zero_q  <= 1'b0;
            resp_dz_q    <= 1'b0;
        end else begin
            if (grant_c) begin
                op_q   <= op_d;
                prio_q <= ~grant_id_c;
            end
            if (state_q == ST_EXEC) begin
                resp_valid_q <= 1'b1;
                resp_id_q    <= op_q.id;
                resp_out_q   <= result_c;
                resp_zero_q  <= (result_c == '0);
                resp_dz_q    <= div0_c;
            end else if ((state_q == ST_RESP) && resp_ready) begin
                resp_valid_q <= 1'b0;
                resp_out_q   <= '0;
                resp_zero_q  <= 1'b0;
                resp_dz_q    <= 1'b0;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_out   = resp_out_q;
    assign resp_zero  = resp_zero_q;
    assign resp_dz    = resp_dz_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_sel = '0, req1_sel = '0;
    logic        resp_valid, resp_id, resp_zero, resp_dz;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_out;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_out(resp_out), .resp_zero(resp_zero), .resp_dz(resp_dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] out;
        logic        zero;
        logic        dz;
        int          due;
    } exp_t;

    exp_t scb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Specification arithmetic in 64-bit integers, truncated to 32 bits.
    function automatic logic [31:0] model_out(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] s);
        longint unsigned aa = 64'(a);
        longint unsigned bb = 64'(b);
        longint unsigned r;
        case (s)
            4'd1:    r = aa + 64'h1_0000_0000 - bb;
            4'd2:    r = aa * bb;
            4'd3:    r = (bb == 0) ? 64'hFFFF_FFFF : aa / bb;
            default: r = aa + bb;
        endcase
        return r[31:0];
    endfunction

    // Transaction-level model: decides who is granted and predicts the response.
    logic m_busy = 1'b0;
    logic m_prio = 1'b0;
    int   m_due  = 0;

    always @(negedge clk) begin
        logic e0, e1, w;
        exp_t e;
        e0 = 1'b0;
        e1 = 1'b0;
        if (reset) begin
            check("ready0_in_reset", 32'(req0_ready), 32'd0);
            check("ready1_in_reset", 32'(req1_ready), 32'd0);
            m_busy = 1'b0;
            m_prio = 1'b0;
            scb.delete();
        end else begin
            if (!m_busy && (req0_valid || req1_valid)) begin
                w = (req0_valid && req1_valid) ? m_prio : req1_valid;
                e.id   = w;
                e.out  = w ? model_out(req1_a, req1_b, req1_sel) : model_out(req0_a, req0_b, req0_sel);
                e.dz   = w ? (req1_sel == 4'd3 && req1_b == 0) : (req0_sel == 4'd3 && req0_b == 0);
                e.zero = (e.out == 32'd0);
                e.due  = cyc + 2;
                scb.push_back(e);
                if (w) e1 = 1'b1; else e0 = 1'b1;
                m_busy = 1'b1;
                m_due  = cyc + 2;
                m_prio = !w;
            end else if (m_busy && cyc >= m_due && resp_ready) begin
                m_busy = 1'b0;
            end
            check("req0_ready", 32'(req0_ready), 32'(e0));
            check("req1_ready", 32'(req1_ready), 32'(e1));
        end
    end

    // Response monitor: pops the scoreboard on each completed handshake.
    logic last_id = 1'b0;
    logic seen    = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            last_id = 1'b0;
            seen    = 1'b0;
        end else if (resp_valid) begin
            if (scb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_resp: got out=%h id=%0d expected no response (cycle %0d)",
                         resp_out, resp_id, cyc);
            end else begin
                if (!seen) begin
                    check("resp_latency", 32'(cyc), 32'(scb[0].due));
                    seen = 1'b1;
                end
                check("resp_out",  resp_out,          scb[0].out);
                check("resp_id",   32'(resp_id),      32'(scb[0].id));
                check("resp_zero", 32'(resp_zero),    32'(scb[0].zero));
                check("resp_dz",   32'(resp_dz),      32'(scb[0].dz));
                if (resp_ready) begin
                    last_id = scb[0].id;
                    void'(scb.pop_front());
                    seen = 1'b0;
                end
            end
        end else begin
            check("idle_out",  resp_out,       32'd0);
            check("idle_zero", 32'(resp_zero), 32'd0);
            check("idle_dz",   32'(resp_dz),   32'd0);
            check("idle_id",   32'(resp_id),   32'(last_id));
            if (scb.size() > 0 && cyc >= scb[0].due) begin
                tests++;
                fails++;
                $display("FAIL missing_resp: got no response expected out=%h id=%0d (cycle %0d)",
                         scb[0].out, scb[0].id, cyc);
                void'(scb.pop_front());
                seen = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    // Present one operation, wait for its grant, then withdraw and scramble operands.
    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel);
        logic got = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        check("grant_wait", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (id) begin
            req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom; req1_sel = 4'($urandom);
        end else begin
            req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; req0_sel = 4'($urandom);
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rand_sel();
        return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        logic g0, g1;
        tick(3);
        reset = 1'b0;

        // Single add on requester 0.
        issue(1'b0, 32'd5, 32'd7, 4'd0);
        tick(3);

        // Contention: both held valid; grants alternate from the reset priority.
        pulse_reset();
        req0_a = 32'd10; req0_b = 32'd10; req0_sel = 4'd1; req0_valid = 1'b1;
        req1_a = 32'd3;  req1_b = 32'd4;  req1_sel = 4'd2; req1_valid = 1'b1;
        tick(12);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(4);

        // Divide by zero and multiply by zero.
        issue(1'b1, 32'd9, 32'd0, 4'd3);
        tick(3);
        issue(1'b1, 32'd9, 32'd0, 4'd2);
        tick(3);

        // Backpressure with the other requester waiting.
        resp_ready = 1'b0;
        issue(1'b0, 32'd100, 32'd23, 4'd1);
        req1_a = 32'd6; req1_b = 32'd2; req1_sel = 4'd3; req1_valid = 1'b1;
        tick(7);
        resp_ready = 1'b1;
        issue(1'b1, 32'd6, 32'd2, 4'd3);
        tick(4);

        // Reset while the operation is in EXEC; no response may follow.
        issue(1'b1, 32'd1, 32'd2, 4'd0);
        pulse_reset();
        tick(4);
        req0_a = 32'd1; req0_b = 32'd1; req0_sel = 4'd0; req0_valid = 1'b1;
        req1_a = 32'd2; req1_b = 32'd2; req1_sel = 4'd0; req1_valid = 1'b1;
        tick(1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(4);

        // Wraparound and undefined opcode.
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 4'd0);
        tick(3);
        issue(1'b1, 32'd2, 32'd3, 4'd9);
        tick(3);

        // Randomized traffic with withdrawals, backpressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g0 = req0_ready;
            g1 = req1_ready;
            @(posedge clk);
            #1;
            if (g0 || (req0_valid && $urandom_range(0, 15) == 0)) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = rand_word(); req0_b = rand_word(); req0_sel = rand_sel();
            end else if (!req0_valid && $urandom_range(0, 3) == 0) begin
                req0_valid = 1'b1;
                req0_a = rand_word(); req0_b = rand_word(); req0_sel = rand_sel();
            end
            if (g1 || (req1_valid && $urandom_range(0, 15) == 0)) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = rand_word(); req1_b = rand_word(); req1_sel = rand_sel();
            end else if (!req1_valid && $urandom_range(0, 3) == 0) begin
                req1_valid = 1'b1;
                req1_a = rand_word(); req1_b = rand_word(); req1_sel = rand_sel();
            end
            resp_ready = ($urandom_range(0, 9) < 6);
            reset      = ($urandom_range(0, 249) == 0);
        end

        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick(10);
        check("drain_empty", 32'(scb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
